// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial adder FSM states and the
// legal operand width range.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // Bit-step counter width; never below one bit so WIDTH=1 still has a counter.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder assembled from two half adders and an OR on the carries.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s_ab;
  logic c_ab;
  logic c_sc;

  half_adder u_ha_ab (
    .x (a),
    .y (b),
    .s (s_ab),
    .c (c_ab)
  );

  half_adder u_ha_sc (
    .x (s_ab),
    .y (cin),
    .s (s),
    .c (c_sc)
  );

  assign cout = c_ab | c_sc;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell and a carry flop
// walk the operands LSB first, with valid/ready handshakes on both sides.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t          state_reg;
  state_t          state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] sum_reg;
  logic            carry_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic [CW-1:0]   cnt_reg;
  logic            fa_s;
  logic            fa_c;
  logic            accept;
  logic            last_step;

  full_adder_cell u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB end so the LSB-first result lands in place.
  if (WIDTH == 1) begin : g_acc_one
    assign acc_shift = fa_s;
  end else begin : g_acc_multi
    assign acc_shift = {fa_s, acc_reg[WIDTH-1:1]};
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;
  assign last_step = (state_reg == BUSY) && (cnt_reg == LAST);

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        // Subtraction is a + ~b + 1: invert B and preload the carry with sub.
        a_reg     <= a;
        b_reg     <= sub ? ~b : b;
        carry_reg <= sub;
        cnt_reg   <= '0;
        acc_reg   <= '0;
      end else if (state_reg == BUSY) begin
        a_reg     <= a_reg >> 1;
        b_reg     <= b_reg >> 1;
        carry_reg <= fa_c;
        acc_reg   <= acc_shift;
        cnt_reg   <= cnt_reg + 1'b1;
        if (last_step) begin
          sum_reg  <= acc_shift;
          cout_reg <= fa_c;
          ovf_reg  <= carry_reg ^ fa_c;
        end
      end
    end
  end

endmodule
